// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : D-stage hazard query bundle between the pipeline and
//               hazard_ctrl (register usage in, stall/forward selects out).
// Revision    : 1.0
// ============================================================================
interface hazard_ctrl_if;
    logic [1:0] Tuse_rs;
    logic [1:0] Tuse_rt;
    logic [1:0] TnewD;
    logic [4:0] A_rsD;
    logic [4:0] A_rtD;
    logic [4:0] AwriteD;
    logic [1:0] md_kindD;
    logic       md_useD;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_rsD;
    logic [1:0] fwd_rtD;
    logic [1:0] fwd_rsE;
    logic [1:0] fwd_rtE;
    logic       fwd_rtM;
    logic       md_busy;

    modport master (
        output Tuse_rs, Tuse_rt, TnewD, A_rsD, A_rtD, AwriteD,
               md_kindD, md_useD, flush,
        input  stall, fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE, fwd_rtM, md_busy
    );

    modport slave (
        input  Tuse_rs, Tuse_rt, TnewD, A_rsD, A_rtD, AwriteD,
               md_kindD, md_useD, flush,
        output stall, fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE, fwd_rtM, md_busy
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Tuse/Tnew hazard unit for a 5-stage pipeline: stall, operand
//               forwarding selects and mult/div busy tracking.
// Revision    : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  wire logic     clk,
    input  wire logic     reset,
    hazard_ctrl_if.slave  bus
);

    localparam int unsigned C_MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int          C_CNT_W   = $clog2(C_MAX_CYC + 1);

    typedef struct packed {
        logic [4:0] a_rs;
        logic [4:0] a_rt;
        logic [4:0] awrite;
        logic [1:0] tnew;
    } entry_t;

    localparam entry_t C_BUBBLE = '0;

    entry_t               r_e, r_m, r_w;
    logic                 r_start_e;
    logic                 r_div_e;
    logic [C_CNT_W-1:0]   r_cnt;

    logic                 w_md_start_d;
    logic                 w_data_stall;
    logic                 w_md_stall;
    logic                 w_stall;
    logic                 w_md_busy;
    logic [1:0]           w_fwd_rsD, w_fwd_rtD, w_fwd_rsE, w_fwd_rtE;
    logic                 w_fwd_rtM;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic entry_t age(input entry_t x);
        entry_t y;
        y      = x;
        y.tnew = sat_dec(x.tnew);
        return y;
    endfunction

    // A producer only blocks when the operand is needed before the result exists.
    function automatic logic src_stall(input logic [1:0] tuse, input logic [4:0] a,
                                       input entry_t e, input entry_t m);
        logic s;
        s = 1'b0;
        if (tuse != 2'd3 && a != 5'd0) begin
            if (tuse < e.tnew && e.awrite == a) s = 1'b1;
            if (tuse < m.tnew && m.awrite == a) s = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [1:0] fwd_d_sel(input logic [4:0] a, input entry_t e,
                                             input entry_t m, input entry_t w);
        logic [1:0] sel;
        sel = 2'd0;
        if (a != 5'd0) begin
            if (e.awrite == a && e.tnew == 2'd0)      sel = 2'd3;
            else if (m.awrite == a && m.tnew == 2'd0) sel = 2'd2;
            else if (w.awrite == a)                   sel = 2'd1;
        end
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic [4:0] a, input entry_t m,
                                             input entry_t w);
        logic [1:0] sel;
        sel = 2'd0;
        if (a != 5'd0) begin
            if (m.awrite == a && m.tnew == 2'd0) sel = 2'd2;
            else if (w.awrite == a)              sel = 2'd1;
        end
        return sel;
    endfunction

    always_comb begin
        w_md_start_d = (bus.md_kindD == 2'd1) || (bus.md_kindD == 2'd2);
        w_md_busy    = (r_cnt != '0);
        w_data_stall = src_stall(bus.Tuse_rs, bus.A_rsD, r_e, r_m) ||
                       src_stall(bus.Tuse_rt, bus.A_rtD, r_e, r_m);
        w_md_stall   = bus.md_useD && (w_md_busy || r_start_e);
        w_stall      = w_data_stall || w_md_stall;
        w_fwd_rsD    = fwd_d_sel(bus.A_rsD, r_e, r_m, r_w);
        w_fwd_rtD    = fwd_d_sel(bus.A_rtD, r_e, r_m, r_w);
        w_fwd_rsE    = fwd_e_sel(r_e.a_rs, r_m, r_w);
        w_fwd_rtE    = fwd_e_sel(r_e.a_rt, r_m, r_w);
        w_fwd_rtM    = (r_m.a_rt != 5'd0) && (r_w.awrite == r_m.a_rt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e       <= C_BUBBLE;
            r_m       <= C_BUBBLE;
            r_w       <= C_BUBBLE;
            r_start_e <= 1'b0;
            r_div_e   <= 1'b0;
        end else begin
            r_w <= age(r_m);
            if (bus.flush) begin
                r_e       <= C_BUBBLE;
                r_m       <= C_BUBBLE;
                r_start_e <= 1'b0;
                r_div_e   <= 1'b0;
            end else begin
                r_m <= age(r_e);
                if (w_stall) begin
                    r_e       <= C_BUBBLE;
                    r_start_e <= 1'b0;
                    r_div_e   <= 1'b0;
                end else begin
                    r_e.a_rs   <= bus.A_rsD;
                    r_e.a_rt   <= bus.A_rtD;
                    r_e.awrite <= bus.AwriteD;
                    r_e.tnew   <= sat_dec(bus.TnewD);
                    r_start_e  <= w_md_start_d;
                    r_div_e    <= (bus.md_kindD == 2'd2);
                end
            end
        end
    end

    // A flush kills the mult/div sitting in E before it can start the unit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_start_e && !bus.flush) begin
            r_cnt <= r_div_e ? C_CNT_W'(DIV_CYC) : C_CNT_W'(MULT_CYC);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - C_CNT_W'(1);
        end
    end

    assign bus.stall   = w_stall;
    assign bus.md_busy = w_md_busy;
    assign bus.fwd_rsD = w_fwd_rsD;
    assign bus.fwd_rtD = w_fwd_rtD;
    assign bus.fwd_rsE = w_fwd_rsE;
    assign bus.fwd_rtE = w_fwd_rtE;
    assign bus.fwd_rtM = w_fwd_rtM;

    wire w_unused = &{1'b0, r_m.a_rs, r_w.a_rs, r_w.a_rt, r_w.tnew};

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed instruction-sequence bench for hazard_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_hazard_ctrl;

    logic clk;
    logic reset;
    int   compared;
    int   failed;

    hazard_ctrl_if bus ();

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [1:0] tus, input logic [1:0] tut, input logic [1:0] tn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                         input logic [1:0] kind, input logic use_md);
        bus.Tuse_rs  = tus;
        bus.Tuse_rt  = tut;
        bus.TnewD    = tn;
        bus.A_rsD    = rs;
        bus.A_rtD    = rt;
        bus.AwriteD  = wr;
        bus.md_kindD = kind;
        bus.md_useD  = use_md;
    endtask

    task automatic set_nop();
        set_d(2'd3, 2'd3, 2'd0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0);
    endtask

    task automatic drain();
        set_nop();
        bus.flush = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.flush = 1'b0;
        set_d(2'd0, 2'd0, 2'd3, 5'd1, 5'd2, 5'd1, 2'd1, 1'b1);
        tick();
        tick();
        compared++;
        if (bus.stall !== 1'b0) begin failed++; $display("FAIL reset_stall got=%0d exp=0", bus.stall); end
        compared++;
        if (bus.md_busy !== 1'b0) begin failed++; $display("FAIL reset_md_busy got=%0d exp=0", bus.md_busy); end
        compared++;
        if ({bus.fwd_rsD, bus.fwd_rtD, bus.fwd_rsE, bus.fwd_rtE, bus.fwd_rtM} !== 9'd0) begin
            failed++;
            $display("FAIL reset_fwd got=%b exp=0", {bus.fwd_rsD, bus.fwd_rtD, bus.fwd_rsE, bus.fwd_rtE, bus.fwd_rtM});
        end
        set_nop();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        drain();
        set_d(2'd3, 2'd3, 2'd3, 5'd0, 5'd0, 5'd1, 2'd0, 1'b0);
        #1;
        compared++;
        if (bus.stall !== 1'b0) begin failed++; $display("FAIL lw_issue_stall got=%0d exp=0", bus.stall); end
        tick();
        set_d(2'd1, 2'd1, 2'd2, 5'd1, 5'd0, 5'd5, 2'd0, 1'b0);
        #1;
        compared++;
        if (bus.stall !== 1'b1) begin failed++; $display("FAIL load_use_stall got=%0d exp=1", bus.stall); end
        tick();
        compared++;
        if (bus.stall !== 1'b0) begin failed++; $display("FAIL load_use_release got=%0d exp=0", bus.stall); end
        tick();
        set_nop();
        #1;
        compared++;
        if (bus.fwd_rsE !== 2'd1) begin failed++; $display("FAIL load_use_fwd_rsE got=%0d exp=1", bus.fwd_rsE); end
        tick();
    endtask

    task automatic test_branch_fwd();
        drain();
        set_d(2'd3, 2'd3, 2'd2, 5'd0, 5'd0, 5'd2, 2'd0, 1'b0);
        tick();
        set_d(2'd0, 2'd0, 2'd0, 5'd2, 5'd0, 5'd0, 2'd0, 1'b0);
        #1;
        compared++;
        if (bus.stall !== 1'b1) begin failed++; $display("FAIL beq_stall got=%0d exp=1", bus.stall); end
        tick();
        compared++;
        if (bus.stall !== 1'b0) begin failed++; $display("FAIL beq_release got=%0d exp=0", bus.stall); end
        compared++;
        if (bus.fwd_rsD !== 2'd2) begin failed++; $display("FAIL beq_fwd_rsD got=%0d exp=2", bus.fwd_rsD); end
        tick();
    endtask

    task automatic test_store_fwd();
        drain();
        set_d(2'd3, 2'd3, 2'd2, 5'd0, 5'd0, 5'd3, 2'd0, 1'b0);
        tick();
        set_d(2'd3, 2'd3, 2'd2, 5'd0, 5'd0, 5'd4, 2'd0, 1'b0);
        tick();
        set_d(2'd1, 2'd2, 2'd0, 5'd0, 5'd3, 5'd0, 2'd0, 1'b0);
        #1;
        compared++;
        if (bus.stall !== 1'b0) begin failed++; $display("FAIL sw_stall got=%0d exp=0", bus.stall); end
        compared++;
        if (bus.fwd_rtD !== 2'd2) begin failed++; $display("FAIL sw_fwd_rtD got=%0d exp=2", bus.fwd_rtD); end
        tick();
        set_nop();
        #1;
        compared++;
        if (bus.fwd_rtE !== 2'd1) begin failed++; $display("FAIL sw_fwd_rtE got=%0d exp=1", bus.fwd_rtE); end
        tick();
    endtask

    task automatic test_back_to_back();
        drain();
        set_d(2'd3, 2'd3, 2'd1, 5'd0, 5'd0, 5'd9, 2'd0, 1'b0);
        tick();
        tick();
        set_d(2'd0, 2'd3, 2'd0, 5'd9, 5'd0, 5'd0, 2'd0, 1'b0);
        #1;
        compared++;
        if (bus.stall !== 1'b0) begin failed++; $display("FAIL b2b_stall got=%0d exp=0", bus.stall); end
        compared++;
        if (bus.fwd_rsD !== 2'd3) begin failed++; $display("FAIL b2b_youngest_fwd got=%0d exp=3", bus.fwd_rsD); end
        tick();
        drain();
        set_d(2'd3, 2'd3, 2'd2, 5'd0, 5'd0, 5'd3, 2'd0, 1'b0);
        tick();
        set_d(2'd1, 2'd2, 2'd0, 5'd0, 5'd3, 5'd0, 2'd0, 1'b0);
        #1;
        compared++;
        if (bus.stall !== 1'b0) begin failed++; $display("FAIL sw_adj_stall got=%0d exp=0", bus.stall); end
        tick();
        set_nop();
        #1;
        compared++;
        if (bus.fwd_rtE !== 2'd2) begin failed++; $display("FAIL sw_adj_fwd_rtE got=%0d exp=2", bus.fwd_rtE); end
        tick();
        compared++;
        if (bus.fwd_rtM !== 1'b1) begin failed++; $display("FAIL sw_adj_fwd_rtM got=%0d exp=1", bus.fwd_rtM); end
        tick();
    endtask

    task automatic test_div_busy();
        int sc;
        int bc;
        sc = 0;
        bc = 0;
        drain();
        set_d(2'd3, 2'd3, 2'd0, 5'd0, 5'd0, 5'd0, 2'd2, 1'b1);
        #1;
        compared++;
        if (bus.stall !== 1'b0) begin failed++; $display("FAIL div_issue_stall got=%0d exp=0", bus.stall); end
        tick();
        set_d(2'd3, 2'd3, 2'd2, 5'd0, 5'd0, 5'd7, 2'd0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            #1;
            if (bus.stall) sc++;
            if (bus.md_busy) bc++;
            if (!bus.stall) break;
            tick();
        end
        compared++;
        if (sc !== 11) begin failed++; $display("FAIL div_stall_cycles got=%0d exp=11", sc); end
        compared++;
        if (bc !== 10) begin failed++; $display("FAIL div_busy_cycles got=%0d exp=10", bc); end
        tick();
    endtask

    task automatic test_zero_reg();
        drain();
        set_d(2'd3, 2'd3, 2'd2, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0);
        tick();
        set_d(2'd0, 2'd0, 2'd2, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0);
        #1;
        compared++;
        if (bus.stall !== 1'b0) begin failed++; $display("FAIL zero_stall got=%0d exp=0", bus.stall); end
        tick();
        compared++;
        if ({bus.fwd_rsD, bus.fwd_rtD, bus.fwd_rsE, bus.fwd_rtE, bus.fwd_rtM} !== 9'd0) begin
            failed++;
            $display("FAIL zero_fwd got=%b exp=0", {bus.fwd_rsD, bus.fwd_rtD, bus.fwd_rsE, bus.fwd_rtE, bus.fwd_rtM});
        end
        tick();
    endtask

    task automatic test_flush();
        drain();
        set_d(2'd3, 2'd3, 2'd2, 5'd0, 5'd0, 5'd5, 2'd0, 1'b0);
        tick();
        set_d(2'd3, 2'd3, 2'd2, 5'd0, 5'd0, 5'd6, 2'd1, 1'b1);
        tick();
        set_d(2'd3, 2'd3, 2'd0, 5'd0, 5'd0, 5'd0, 2'd2, 1'b1);
        bus.flush = 1'b1;
        #1;
        compared++;
        if (bus.stall !== 1'b1) begin failed++; $display("FAIL flush_pre_stall got=%0d exp=1", bus.stall); end
        tick();
        bus.flush = 1'b0;
        set_d(2'd0, 2'd0, 2'd0, 5'd5, 5'd6, 5'd0, 2'd0, 1'b1);
        #1;
        compared++;
        if (bus.stall !== 1'b0) begin failed++; $display("FAIL flush_stall got=%0d exp=0", bus.stall); end
        compared++;
        if ({bus.fwd_rsD, bus.fwd_rtD} !== 4'b0100) begin
            failed++;
            $display("FAIL flush_fwd got=%b exp=0100", {bus.fwd_rsD, bus.fwd_rtD});
        end
        set_nop();
        tick();
        compared++;
        if (bus.md_busy !== 1'b0) begin failed++; $display("FAIL flush_no_start got=%0d exp=0", bus.md_busy); end
        tick();
    endtask

    task automatic test_reset_mid_mult();
        drain();
        set_d(2'd3, 2'd3, 2'd0, 5'd0, 5'd0, 5'd0, 2'd1, 1'b1);
        tick();
        set_nop();
        repeat (3) tick();
        set_d(2'd3, 2'd3, 2'd2, 5'd0, 5'd0, 5'd8, 2'd0, 1'b1);
        #1;
        compared++;
        if ({bus.stall, bus.md_busy} !== 2'b11) begin
            failed++;
            $display("FAIL mult_count_busy got=%b exp=11", {bus.stall, bus.md_busy});
        end
        reset = 1'b0;
        #1;
        compared++;
        if ({bus.stall, bus.md_busy} !== 2'b00) begin
            failed++;
            $display("FAIL async_reset_abort got=%b exp=00", {bus.stall, bus.md_busy});
        end
        tick();
        reset = 1'b1;
        #1;
        compared++;
        if ({bus.stall, bus.md_busy} !== 2'b00) begin
            failed++;
            $display("FAIL post_reset_mflo got=%b exp=00", {bus.stall, bus.md_busy});
        end
        tick();
        set_nop();
        compared++;
        if (bus.md_busy !== 1'b0) begin failed++; $display("FAIL post_reset_busy got=%0d exp=0", bus.md_busy); end
        tick();
    endtask

    initial begin
        compared = 0;
        failed   = 0;
        reset    = 1'b0;
        bus.flush = 1'b0;
        set_nop();
        test_reset();
        test_load_use();
        test_branch_fwd();
        test_store_fwd();
        test_back_to_back();
        test_div_busy();
        test_zero_reg();
        test_flush();
        test_reset_mid_mult();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
`default_nettype wire
